float_to_decimal_seq: RTL and testbench

Sequential float-to-decimal converter for the FLOAT_TO_DECIMAL path. It accepts an IEEE-754 single-precision word over a valid/ready handshake and splits the significand into an integer part and a 23-bit binary fraction according to the exponent. It then emits NDIG BCD fraction digits using one multiply-by-10 step per cycle, and returns the result over a second valid/ready handshake. It sits between the float source and the decimal display/formatting logic.

---
 rtl/float_to_decimal_seq_if.sv | 22 ++
 rtl/float_to_decimal_seq.sv | 137 +++++++++++++
 tb/tb_float_to_decimal_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/float_to_decimal_seq_if.sv
// float_to_decimal_seq_if: input and result handshakes of the float-to-decimal converter
// master drives in_valid/in_data/out_ready; slave returns in_ready and the result bundle.
interface float_to_decimal_seq_if #(parameter int NDIG = 4);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [23:0]         out_int;
  logic [4*NDIG-1:0]   out_frac;
  logic                out_ovf;
  logic                out_unf;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_int, out_frac, out_ovf, out_unf
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_int, out_frac, out_ovf, out_unf
  );
endinterface

// File: rtl/float_to_decimal_seq.sv
// float_to_decimal_seq: IEEE-754 single to integer part plus NDIG truncated BCD fraction digits
// ports: clk, rst (sync, active high), bus (float_to_decimal_seq_if.slave)
// FTD_ROUND_LAST_DIGIT_EN adds a ROUND state that rounds on one extra digit
module float_to_decimal_seq #(
  parameter int NDIG = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  float_to_decimal_seq_if.slave  bus
);
  localparam int W = 4 * NDIG;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPLIT = 3'd1;
  localparam logic [2:0] S_DIGIT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FTD_ROUND_LAST_DIGIT_EN
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_AFTER = S_ROUND;
`else
  localparam logic [2:0] S_AFTER = S_DONE;
`endif
  logic [2:0]   r_state;
  logic [31:0]  r_word;
  logic [22:0]  r_frac;
  logic [3:0]   r_k;
  logic         r_sign;
  logic         r_ovf;
  logic         r_unf;
  logic [23:0]  r_int;
  logic [W-1:0] r_digits;
  logic [7:0]   w_e;
  logic [7:0]   w_up;
  logic [7:0]   w_dn;
  logic [22:0]  w_m;
  logic [23:0]  w_mm;
  logic [22:0]  w_shr;
  logic [23:0]  w_sp_int;
  logic [22:0]  w_sp_frac;
  logic         w_sp_ovf;
  logic         w_sp_unf;
  logic [26:0]  w_p;
  assign w_e   = r_word[30:23];
  assign w_m   = r_word[22:0];
  assign w_mm  = {1'b1, w_m};
  assign w_up  = w_e - 8'd127;
  assign w_dn  = 8'd127 - w_e;
  // the bit weighted 2^-1 of a value below one is M >> (127-e) in 23-bit fraction units
  assign w_shr = 23'(w_mm >> w_dn[4:0]);
  assign w_p   = {1'b0, r_frac, 3'b000} + {3'b000, r_frac, 1'b0};
  always_comb begin
    w_sp_int  = '0;
    w_sp_frac = '0;
    w_sp_ovf  = 1'b0;
    w_sp_unf  = 1'b0;
    if (w_e == 8'd0)
      w_sp_unf = |w_m;
    else if (w_e == 8'd255 || (w_e >= 8'd127 && w_up > 8'd23)) begin
      w_sp_ovf = 1'b1;
      w_sp_int = '1;
    end else if (w_e >= 8'd127) begin
      w_sp_int  = w_mm >> (5'd23 - w_up[4:0]);
      w_sp_frac = w_m << w_up[4:0];
    end else if (w_dn > 8'd23)
      w_sp_unf = 1'b1;
    else
      w_sp_frac = w_shr;
  end
`ifdef FTD_ROUND_LAST_DIGIT_EN
  logic [W-1:0] w_inc;
  logic         w_cout;
  always_comb begin
    w_cout = 1'b1;
    w_inc  = r_digits;
    for (int i = 0; i < NDIG; i++) begin
      w_inc[4*i +: 4] = w_cout ? ((r_digits[4*i +: 4] == 4'd9) ? 4'd0 : r_digits[4*i +: 4] + 4'd1) : r_digits[4*i +: 4];
      w_cout = w_cout & (r_digits[4*i +: 4] == 4'd9);
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_frac   <= '0;
      r_k      <= '0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_int    <= '0;
      r_digits <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_word  <= bus.in_data;
          r_state <= S_SPLIT;
        end
        S_SPLIT: begin
          r_sign   <= r_word[31];
          r_int    <= w_sp_int;
          r_frac   <= w_sp_frac;
          r_ovf    <= w_sp_ovf;
          r_unf    <= w_sp_unf;
          r_digits <= '0;
          r_k      <= '0;
          r_state  <= S_DIGIT;
        end
        S_DIGIT: begin
          r_digits <= (r_digits << 4) | W'(w_p[26:23]);
          r_frac   <= w_p[22:0];
          r_k      <= r_k + 4'd1;
          r_state  <= (r_k == 4'(NDIG - 1)) ? S_AFTER : S_DIGIT;
        end
`ifdef FTD_ROUND_LAST_DIGIT_EN
        S_ROUND: begin
          if (w_p[26:23] >= 4'd5) begin
            r_digits <= w_inc;
            if (w_cout) begin
              r_int <= (&r_int) ? r_int : r_int + 24'd1;
              r_ovf <= r_ovf | (&r_int);
            end
          end
          r_state <= S_DONE;
        end
`endif
        S_DONE: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready  = r_state == S_IDLE;
  assign bus.out_valid = r_state == S_DONE;
  assign bus.out_sign  = r_sign;
  assign bus.out_int   = r_int;
  assign bus.out_frac  = r_digits;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_unf   = r_unf;
endmodule

// File: tb/tb_float_to_decimal_seq.sv
// tb_float_to_decimal_seq: vector table, corner sequences and random words against a real-valued model
module tb_float_to_decimal_seq;
  localparam int NDIG = 4;
`ifdef FTD_ROUND_LAST_DIGIT_EN
  localparam int LAT = NDIG + 3;
`else
  localparam int LAT = NDIG + 2;
`endif
  typedef struct packed {
    logic              sign;
    logic [23:0]       i;
    logic [4*NDIG-1:0] f;
    logic              ovf;
    logic              unf;
  } res_t;
  typedef struct {
    logic [31:0] w;
    res_t        r;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  float_to_decimal_seq_if #(.NDIG(NDIG)) bus ();
  float_to_decimal_seq #(.NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] w);
    res_t r;
    int e;
    real v;
    longint fx, f, q, p10;
    r = '0;
    r.sign = w[31];
    e = int'(w[30:23]);
    if (e == 255) begin
      r.ovf = 1'b1;
      r.i = 24'hFFFFFF;
      return r;
    end
    if (e == 0) begin
      r.unf = w[22:0] != 0;
      return r;
    end
    v = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    if (v >= 16777216.0) begin
      r.ovf = 1'b1;
      r.i = 24'hFFFFFF;
      return r;
    end
    if (v < 2.0 ** (-23)) begin
      r.unf = 1'b1;
      return r;
    end
    fx = longint'($floor(v * 8388608.0));
    r.i = 24'(fx / 8388608);
    f = fx % 8388608;
    p10 = 1;
    for (int k = 0; k < NDIG; k++) p10 = p10 * 10;
    q = (f * p10) / 8388608;
`ifdef FTD_ROUND_LAST_DIGIT_EN
    if ((f * p10 * 10 / 8388608) % 10 >= 5) q = q + 1;
    if (q == p10) begin
      q = 0;
      if (r.i == 24'hFFFFFF) r.ovf = 1'b1;
      else r.i = r.i + 24'd1;
    end
`endif
    for (int k = 0; k < NDIG; k++) begin
      r.f[4*k +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction
  task automatic convert(input logic [31:0] w, output res_t got, output int lat);
    int n;
    bus.in_data = w;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", bus.out_valid, 1);
    got = {bus.out_sign, bus.out_int, bus.out_frac, bus.out_ovf, bus.out_unf};
    @(negedge clk);
    chk("in_ready_after", bus.in_ready, 1);
    chk("out_valid_drop", bus.out_valid, 0);
  endtask
  task automatic cmp(input string tag, input res_t got, input res_t exp);
    chk({tag, ".sign"}, got.sign, exp.sign);
    chk({tag, ".int"},  got.i,    exp.i);
    chk({tag, ".frac"}, got.f,    exp.f);
    chk({tag, ".ovf"},  got.ovf,  exp.ovf);
    chk({tag, ".unf"},  got.unf,  exp.unf);
    chk({tag, ".excl"}, got.ovf & got.unf, 0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, ".in_ready"},  bus.in_ready, 1);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".sign"},      bus.out_sign, 0);
    chk({tag, ".int"},       bus.out_int, 0);
    chk({tag, ".frac"},      bus.out_frac, 0);
    chk({tag, ".ovf"},       bus.out_ovf, 0);
    chk({tag, ".unf"},       bus.out_unf, 0);
  endtask
  vec_t tbl[9];
  initial begin
    res_t got;
    int lat, n;
    logic [31:0] w;
    tbl[0] = '{32'h40B80000, '{1'b0, 24'd5,       16'h7500, 1'b0, 1'b0}};
`ifdef FTD_ROUND_LAST_DIGIT_EN
    tbl[1] = '{32'hBDCCCCCD, '{1'b1, 24'd0,       16'h1000, 1'b0, 1'b0}};
    tbl[8] = '{32'h3F7FFFFF, '{1'b0, 24'd1,       16'h0000, 1'b0, 1'b0}};
`else
    tbl[1] = '{32'hBDCCCCCD, '{1'b1, 24'd0,       16'h0999, 1'b0, 1'b0}};
    tbl[8] = '{32'h3F7FFFFF, '{1'b0, 24'd0,       16'h9999, 1'b0, 1'b0}};
`endif
    tbl[2] = '{32'h501502F9, '{1'b0, 24'hFFFFFF,  16'h0000, 1'b1, 1'b0}};
    tbl[3] = '{32'h7F800000, '{1'b0, 24'hFFFFFF,  16'h0000, 1'b1, 1'b0}};
    tbl[4] = '{32'h00000000, '{1'b0, 24'd0,       16'h0000, 1'b0, 1'b0}};
    tbl[5] = '{32'h00000001, '{1'b0, 24'd0,       16'h0000, 1'b0, 1'b1}};
    tbl[6] = '{32'h3F800000, '{1'b0, 24'd1,       16'h0000, 1'b0, 1'b0}};
    tbl[7] = '{32'h3F000000, '{1'b0, 24'd0,       16'h5000, 1'b0, 1'b0}};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");
    for (int t = 0; t < 9; t++) begin
      convert(tbl[t].w, got, lat);
      cmp($sformatf("vec%0d", t), got, tbl[t].r);
      chk($sformatf("vec%0d.latency", t), lat, LAT);
    end
    bus.in_data = 32'h41480000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold.valid", bus.out_valid, 1);
    for (int c = 0; c < 3; c++) begin
      chk("hold.int", bus.out_int, 24'd12);
      chk("hold.frac", bus.out_frac, 16'h5000);
      chk("hold.in_ready", bus.in_ready, 0);
      chk("hold.out_valid", bus.out_valid, 1);
      bus.in_data = 32'h3F800000;
      bus.in_valid = c == 0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("hold.int_last", bus.out_int, 24'd12);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold.in_ready_after", bus.in_ready, 1);
    chk("hold.valid_drop", bus.out_valid, 0);
    repeat (3) @(negedge clk);
    chk("hold.ignored_valid", bus.out_valid, 0);
    chk("hold.ignored_int", bus.out_int, 24'd12);
    bus.in_data = 32'h40B80000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid_reset");
    convert(32'h3F800000, got, lat);
    cmp("after_reset", got, '{1'b0, 24'd1, 16'h0000, 1'b0, 1'b0});
    for (int t = 0; t < 150; t++) begin
      w = $urandom;
      if (t % 4 != 0) w[30:23] = 8'($urandom_range(100, 154));
      convert(w, got, lat);
      cmp($sformatf("rand_%08h", w), got, model(w));
      chk("rand.latency", lat, LAT);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
